// File: rtl/add3_serial_frontend_if.sv
// add3_serial_frontend_if: serial operand input stream and parallel result output stream
interface add3_serial_frontend_if;
  logic       in_valid;
  logic       in_sof;
  logic       in_bit;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_ready;
  modport master(output in_valid, in_sof, in_bit, out_ready, input in_ready, out_valid, out_data);
  modport slave(input in_valid, in_sof, in_bit, out_ready, output in_ready, out_valid, out_data);
endinterface

// File: rtl/add3_serial_frontend.sv
// add3_serial_frontend: deserialises a 7-bit operand frame for add3 and returns its registered result
module add3_serial_frontend #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  add3_serial_frontend_if.slave        bus,
  output logic [2:0]                   add_x,
  output logic [2:0]                   add_y,
  output logic                         add_c_in,
  input  logic [2:0]                   add_s,
  input  logic                         add_c_out,
  output logic                         frame_err,
  output logic                         add_err
);
  typedef enum logic [1:0] {LOAD, EVAL, OUT} state_t;
  state_t     state;
  logic [2:0] cnt;
  logic [3:0] out_data_q;
  logic       out_valid_q;
  logic [3:0] exp_sum;
  assign bus.in_ready  = state == LOAD;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign exp_sum = {1'b0, add_x} + {1'b0, add_y} + {3'b0, add_c_in};
  // x and y bits arrive LSB first in that order, so one 6-bit right shift lands them in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= LOAD;
      cnt         <= '0;
      add_x       <= '0;
      add_y       <= '0;
      add_c_in    <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      frame_err   <= 1'b0;
      add_err     <= 1'b0;
    end else begin
      case (state)
        LOAD: if (bus.in_valid) begin
          if (bus.in_sof) begin
            add_c_in <= bus.in_bit;
            cnt      <= 3'd1;
            if (cnt != 3'd0) frame_err <= 1'b1;
          end else if (cnt != 3'd0) begin
            {add_y, add_x} <= {bus.in_bit, add_y, add_x[2:1]};
            cnt            <= cnt == 3'd6 ? 3'd0 : cnt + 3'd1;
            if (cnt == 3'd6) state <= EVAL;
          end
        end
        EVAL: begin
          out_data_q  <= {add_c_out, add_s};
          out_valid_q <= 1'b1;
          state       <= OUT;
          if (CHECK_EN && {add_c_out, add_s} != exp_sum) add_err <= 1'b1;
        end
        OUT: if (bus.out_ready) begin
          out_valid_q <= 1'b0;
          state       <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end
endmodule

// File: tb/tb_add3_serial_frontend.sv
// tb_add3_serial_frontend: directed vectors plus multi-cycle corner sequences for add3_serial_frontend
module tb_add3_serial_frontend;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic corrupt = 1'b0;
  int   nvec = 0;
  int   nerr = 0;

  add3_serial_frontend_if bus();
  add3_serial_frontend_if bus0();
  logic [2:0] add_x, add_y, add_s, add_x0, add_y0, add_s0;
  logic       add_c_in, add_c_out, add_c_in0, add_c_out0;
  logic       frame_err, add_err, frame_err0, add_err0;

  // behavioural add3 with an optional fault on s[0]
  assign {add_c_out, add_s}   = ({1'b0, add_x} + {1'b0, add_y} + {3'b0, add_c_in}) ^ {3'b0, corrupt};
  assign {add_c_out0, add_s0} = ({1'b0, add_x0} + {1'b0, add_y0} + {3'b0, add_c_in0}) ^ {3'b0, corrupt};
  assign bus0.in_valid  = bus.in_valid;
  assign bus0.in_sof    = bus.in_sof;
  assign bus0.in_bit    = bus.in_bit;
  assign bus0.out_ready = bus.out_ready;

  add3_serial_frontend #(.CHECK_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .add_x(add_x), .add_y(add_y), .add_c_in(add_c_in),
    .add_s(add_s), .add_c_out(add_c_out), .frame_err(frame_err), .add_err(add_err));
  add3_serial_frontend #(.CHECK_EN(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .add_x(add_x0), .add_y(add_y0), .add_c_in(add_c_in0),
    .add_s(add_s0), .add_c_out(add_c_out0), .frame_err(frame_err0), .add_err(add_err0));

  always #5 clk = ~clk;

  typedef struct {
    logic       c_in;
    logic [2:0] x;
    logic [2:0] y;
    int         junk;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic sof, input logic b);
    bus.in_valid = 1'b1;
    bus.in_sof   = sof;
    bus.in_bit   = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
  endtask

  task automatic send_frame(input logic c, input logic [2:0] x, input logic [2:0] y, input int gap);
    logic [6:0] f;
    f = {y, x, c};
    for (int i = 0; i < 7; i++) begin
      if (i > 0) repeat ($urandom_range(0, gap)) begin
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'($urandom);
        @(posedge clk); #1;
      end
      send_bit(i == 0, f[i]);
    end
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.out_valid) check("out_valid_timeout", 8'(bus.out_valid), 8'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.in_bit = 1'b0; bus.out_ready = 1'b1;
    vecs[0] = '{1'b0, 3'b110, 3'b101, 0, 4'b1011};
    vecs[1] = '{1'b1, 3'b111, 3'b111, 2, 4'b1111};
    vecs[2] = '{1'b0, 3'b000, 3'b000, 1, 4'b0000};
    vecs[3] = '{1'b1, 3'b100, 3'b010, 3, 4'b0111};
    vecs[4] = '{1'b0, 3'b111, 3'b001, 0, 4'b1000};
    vecs[5] = '{1'b1, 3'b011, 3'b001, 1, 4'b0101};
    @(posedge clk); #1;
    check("rst_in_ready", 8'(bus.in_ready), 8'd1);
    check("rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("rst_out_data", 8'(bus.out_data), 8'd0);
    check("rst_xy", {add_c_in, add_y, add_x}, 8'd0);
    check("rst_flags", {frame_err, add_err}, 8'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // basic frame with exact timing
    send_frame(1'b0, 3'b110, 3'b101, 0);
    check("basic_eval_in_ready", 8'(bus.in_ready), 8'd0);
    check("basic_eval_out_valid", 8'(bus.out_valid), 8'd0);
    @(posedge clk); #1;
    check("basic_out_valid", 8'(bus.out_valid), 8'd1);
    check("basic_out_data", 8'(bus.out_data), 8'b1011);
    @(posedge clk); #1;
    check("basic_valid_drop", 8'(bus.out_valid), 8'd0);
    check("basic_back_to_load", 8'(bus.in_ready), 8'd1);

    // table: leading non-sof bits must be discarded without raising frame_err
    foreach (vecs[k]) begin
      repeat (vecs[k].junk) send_bit(1'b0, 1'b1);
      send_frame(vecs[k].c_in, vecs[k].x, vecs[k].y, k % 3);
      wait_out();
      check($sformatf("vec%0d_out_data", k), 8'(bus.out_data), 8'(vecs[k].exp));
      check($sformatf("vec%0d_frame_err", k), 8'(frame_err), 8'd0);
      @(posedge clk); #1;
    end
    check("no_add_err_clean", 8'(add_err), 8'd0);

    // backpressure
    bus.out_ready = 1'b0;
    send_frame(1'b1, 3'b100, 3'b010, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", 8'(bus.out_valid), 8'd1);
      check("bp_out_data", 8'(bus.out_data), 8'b0111);
      check("bp_in_ready", 8'(bus.in_ready), 8'd0);
      check("bp_xy", {2'b0, add_y, add_x}, 8'b00_010_100);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_released_valid", 8'(bus.out_valid), 8'd0);
    check("bp_released_in_ready", 8'(bus.in_ready), 8'd1);

    // idle gaps inside a frame
    do_reset();
    send_frame(1'b1, 3'b011, 3'b001, 3);
    wait_out();
    check("gap_out_data", 8'(bus.out_data), 8'b0101);
    check("gap_frame_err", 8'(frame_err), 8'd0);
    @(posedge clk); #1;

    // restart mid-frame
    send_bit(1'b1, 1'b0);
    repeat (3) send_bit(1'b0, 1'b1);
    send_frame(1'b1, 3'b111, 3'b111, 0);
    wait_out();
    check("restart_frame_err", 8'(frame_err), 8'd1);
    check("restart_out_data", 8'(bus.out_data), 8'b1111);
    @(posedge clk); #1;

    // adder fault: s[0] flipped
    do_reset();
    corrupt = 1'b1;
    send_frame(1'b0, 3'b110, 3'b101, 0);
    wait_out();
    corrupt = 1'b0;
    check("fault_out_data", 8'(bus.out_data), 8'b1010);
    check("fault_add_err_en", 8'(add_err), 8'd1);
    check("fault_add_err_dis", 8'(add_err0), 8'd0);
    @(posedge clk); #1;

    // reset while OUT
    bus.out_ready = 1'b0;
    send_frame(1'b1, 3'b111, 3'b111, 0);
    @(posedge clk); #1;
    check("pre_rst_out_valid", 8'(bus.out_valid), 8'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 8'(bus.out_valid), 8'd0);
    check("mid_rst_out_data", 8'(bus.out_data), 8'd0);
    check("mid_rst_xy", {add_c_in, add_y, add_x}, 8'd0);
    check("mid_rst_flags", {frame_err, add_err}, 8'd0);
    check("mid_rst_in_ready", 8'(bus.in_ready), 8'd1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    send_frame(1'b0, 3'b111, 3'b001, 0);
    wait_out();
    check("post_rst_out_data", 8'(bus.out_data), 8'b1000);
    @(posedge clk); #1;
    check("post_rst_valid_drop", 8'(bus.out_valid), 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
